// File: rtl/tmr_frame_sched.sv
// Frame scheduler for the two-stage TMR neuron datapath: sweeps stage-1 rows,
// drives stage 2 one cycle behind, and recovers from TMR fault flags by row retry or frame restart.
module tmr_frame_sched #(
  parameter int S           = 8,
  parameter int AW          = 3,
  parameter int MAX_RETRY   = 3,
  parameter int FRAME_RETRY = 2,
  parameter int CNTW        = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            rfflag,
  input  logic            cfflag,
  output logic [AW-1:0]   addr_r,
  output logic [AW-1:0]   addr_c,
  output logic            en_s2,
  output logic            clr_s2,
  output logic            busy,
  output logic            err,
  output logic [CNTW-1:0] fault_cnt
);

  localparam int RRW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int FRW = (FRAME_RETRY < 1) ? 1 : $clog2(FRAME_RETRY + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t         state_r;
  logic [RRW-1:0] row_retry_r;
  logic [FRW-1:0] frame_retry_r;

  logic active_s;
  logic cf_q_s;
  logic rf_q_s;
  logic fault_s;
  logic last_row_s;

  // A stage-2 flag only counts when stage 2 was actually accumulating this cycle
  assign active_s   = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign cf_q_s     = cfflag & en_s2 & active_s;
  assign rf_q_s     = rfflag & (state_r == ST_RUN);
  assign fault_s    = cf_q_s | rf_q_s;
  assign last_row_s = (addr_r == AW'(S - 1));

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign err       = (state_r == ST_ERR);
  assign busy      = active_s;

  // Saturating count of cycles carrying at least one qualified fault
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_cnt <= {CNTW{1'b0}};
    end else if (fault_s && (fault_cnt != {CNTW{1'b1}})) begin
      fault_cnt <= fault_cnt + CNTW'(1);
    end else begin
      fault_cnt <= fault_cnt;
    end
  end

  // Frame sequencing FSM with registered datapath controls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      addr_r        <= {AW{1'b0}};
      addr_c        <= {AW{1'b0}};
      en_s2         <= 1'b0;
      clr_s2        <= 1'b0;
      row_retry_r   <= {RRW{1'b0}};
      frame_retry_r <= {FRW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          en_s2         <= 1'b0;
          clr_s2        <= 1'b0;
          row_retry_r   <= {RRW{1'b0}};
          frame_retry_r <= {FRW{1'b0}};
          if (in_valid) begin
            state_r <= ST_RUN;
            addr_r  <= {AW{1'b0}};
            clr_s2  <= 1'b1;
          end
        end
        ST_RUN, ST_DRAIN: begin
          addr_c <= addr_r;
          clr_s2 <= 1'b0;
          // Stage-2 fault outranks a simultaneous stage-1 fault: the whole frame reruns
          if (cf_q_s) begin
            en_s2 <= 1'b0;
            if (frame_retry_r == FRW'(FRAME_RETRY)) begin
              state_r <= ST_ERR;
            end else begin
              state_r       <= ST_RUN;
              addr_r        <= {AW{1'b0}};
              clr_s2        <= 1'b1;
              row_retry_r   <= {RRW{1'b0}};
              frame_retry_r <= frame_retry_r + FRW'(1);
            end
          end else if (state_r == ST_DRAIN) begin
            state_r <= ST_DONE;
            en_s2   <= 1'b0;
          end else if (rfflag) begin
            en_s2 <= 1'b0;
            if (row_retry_r == RRW'(MAX_RETRY)) begin
              state_r <= ST_ERR;
            end else begin
              row_retry_r <= row_retry_r + RRW'(1);
            end
          end else begin
            en_s2       <= 1'b1;
            row_retry_r <= {RRW{1'b0}};
            if (last_row_s) begin
              state_r <= ST_DRAIN;
            end else begin
              addr_r <= addr_r + AW'(1);
            end
          end
        end
        ST_DONE: begin
          en_s2  <= 1'b0;
          clr_s2 <= 1'b0;
          if (out_ready) begin
            state_r <= ST_IDLE;
          end
        end
        ST_ERR: begin
          en_s2  <= 1'b0;
          clr_s2 <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          en_s2   <= 1'b0;
          clr_s2  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_frame_sched.sv
// Self-checking bench for tmr_frame_sched: per-scenario tasks plus an addr_c scoreboard
// that is filled as frames are launched and drained whenever en_s2 is observed.
module tb_tmr_frame_sched;

  localparam int S    = 8;
  localparam int AW   = 3;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            rfflag = 1'b0;
  logic            cfflag = 1'b0;
  logic            in_ready, out_valid, en_s2, clr_s2, busy, err;
  logic [AW-1:0]   addr_r, addr_c;
  logic [CNTW-1:0] fault_cnt;

  int              n_chk = 0;
  int              n_fail = 0;
  int              cyc = 0;
  logic [CNTW-1:0] exp_cnt = 8'd0;
  logic [AW-1:0]   sb_q[$];

  localparam logic [19:0] RST_VEC = {1'b1, 5'b00000, 3'd0, 3'd0, 8'd0};
  wire [19:0] outs = {in_ready, out_valid, busy, err, en_s2, clr_s2, addr_r, addr_c, fault_cnt};

  tmr_frame_sched #(.S(S), .AW(AW), .MAX_RETRY(3), .FRAME_RETRY(2), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .rfflag(rfflag), .cfflag(cfflag),
    .addr_r(addr_r), .addr_c(addr_c), .en_s2(en_s2), .clr_s2(clr_s2),
    .busy(busy), .err(err), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every stage-2 accumulate must match the next expected column
  always @(negedge clk) begin
    if (reset && en_s2) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_en: en_s2=1 addr_c=%0d with nothing expected (cyc %0d)", addr_c, cyc);
      end else begin
        logic [AW-1:0] e;
        e = sb_q.pop_front();
        if (addr_c !== e) begin
          n_fail++;
          $display("FAIL sb_addr_c: got %0d expected %0d (cyc %0d)", addr_c, e, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_cols(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) sb_q.push_back(AW'(i));
  endtask

  task automatic bump(input int n);
    for (int i = 0; i < n; i++)
      if (exp_cnt != {CNTW{1'b1}}) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic accept();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input int exp_c, input string nm);
    int n = 0;
    while (!out_valid && n < 80) begin
      tick();
      n++;
    end
    n_chk++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid never rose, got cycle %0d expected %0d", nm, cyc, exp_c);
    end else if (cyc !== exp_c) begin
      n_fail++;
      $display("FAIL %s_latency: out_valid at cycle %0d expected %0d", nm, cyc, exp_c);
    end
  endtask

  task automatic do_reset();
    sb_q.delete();
    in_valid = 1'b0; rfflag = 1'b0; cfflag = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    exp_cnt = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b1;
    #2;
    n_chk++;
    if (outs !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", outs, RST_VEC);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (outs !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", outs, RST_VEC);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fault_free();
    out_ready = 1'b1;
    push_cols(0, 7);
    accept();
    for (int k = 1; k <= 11; k++) begin
      n_chk += 4;
      if (k <= 8) begin
        n_chk++;
        if (addr_r !== AW'(k - 1)) begin
          n_fail++; $display("FAIL ff_addr_r: cycle %0d got %0d expected %0d", k, addr_r, k - 1);
        end
      end
      if (clr_s2 !== (k == 1)) begin
        n_fail++; $display("FAIL ff_clr_s2: cycle %0d got %0b expected %0b", k, clr_s2, (k == 1));
      end
      if (en_s2 !== (k >= 2 && k <= 9)) begin
        n_fail++; $display("FAIL ff_en_s2: cycle %0d got %0b expected %0b", k, en_s2, (k >= 2 && k <= 9));
      end
      if (out_valid !== (k == 10)) begin
        n_fail++; $display("FAIL ff_out_valid: cycle %0d got %0b expected %0b", k, out_valid, (k == 10));
      end
      if (in_ready !== (k == 11)) begin
        n_fail++; $display("FAIL ff_in_ready: cycle %0d got %0b expected %0b", k, in_ready, (k == 11));
      end
      if (k < 11) tick();
    end
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL ff_sb_left: got %0d columns left expected 0", sb_q.size());
    end
  endtask

  task automatic test_row_retry();
    push_cols(0, 7);
    accept();
    while (cyc < 4) tick();
    rfflag = 1'b1;
    tick();
    rfflag = 1'b0;
    bump(1);
    n_chk += 2;
    if (addr_r !== 3'd3) begin
      n_fail++; $display("FAIL rr_hold: addr_r got %0d expected 3", addr_r);
    end
    if (en_s2 !== 1'b0) begin
      n_fail++; $display("FAIL rr_en_gap: en_s2 got %0b expected 0", en_s2);
    end
    tick();
    n_chk++;
    if (addr_r !== 3'd4) begin
      n_fail++; $display("FAIL rr_advance: addr_r got %0d expected 4", addr_r);
    end
    wait_done(11, "rr");
    n_chk += 2;
    if (fault_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL rr_fault_cnt: got %0d expected %0d", fault_cnt, exp_cnt);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL rr_sb_left: got %0d expected 0", sb_q.size());
    end
    tick();
  endtask

  task automatic test_row_fatal();
    int nflags = 0;
    push_cols(0, 4);
    accept();
    for (int n = 0; n < 30 && !err; n++) begin
      rfflag = busy && (addr_r == 3'd5);
      if (rfflag) nflags++;
      tick();
    end
    rfflag = 1'b0;
    bump(nflags);
    n_chk += 4;
    if (err !== 1'b1 || cyc !== 10) begin
      n_fail++; $display("FAIL rf_err_entry: err=%0b at cycle %0d expected err=1 at cycle 10", err, cyc);
    end
    if (nflags !== 4) begin
      n_fail++; $display("FAIL rf_flag_count: got %0d flags expected 4", nflags);
    end
    if (fault_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL rf_fault_cnt: got %0d expected %0d", fault_cnt, exp_cnt);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL rf_sb_left: got %0d expected 0", sb_q.size());
    end
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      n_chk++;
      if (err !== 1'b1 || in_ready !== 1'b0 || en_s2 !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rf_err_sticky: err=%0b in_ready=%0b en_s2=%0b busy=%0b expected 1 0 0 0", err, in_ready, en_s2, busy);
      end
    end
    in_valid = 1'b0;
    do_reset();
    n_chk++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rf_err_cleared: err=%0b in_ready=%0b expected 0 1", err, in_ready);
    end
  endtask

  task automatic test_frame_restart();
    int tgt[3] = '{6, 7, 2};
    int pass = 0;
    push_cols(0, 6);
    accept();
    for (int n = 0; n < 60 && !err; n++) begin
      cfflag = (pass < 3) && en_s2 && (addr_c == AW'(tgt[pass]));
      tick();
      if (cfflag) begin
        bump(1);
        pass++;
        if (pass == 1) push_cols(0, 7);
        if (pass == 2) push_cols(0, 2);
        if (pass < 3) begin
          n_chk++;
          if (addr_r !== 3'd0 || clr_s2 !== 1'b1 || en_s2 !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL fr_restart%0d: addr_r=%0d clr_s2=%0b en_s2=%0b busy=%0b expected 0 1 0 1", pass, addr_r, clr_s2, en_s2, busy);
          end
        end
      end
      cfflag = 1'b0;
    end
    n_chk += 3;
    if (err !== 1'b1 || cyc !== 22) begin
      n_fail++; $display("FAIL fr_err_entry: err=%0b at cycle %0d expected err=1 at cycle 22", err, cyc);
    end
    if (fault_cnt !== exp_cnt || exp_cnt !== 8'd3) begin
      n_fail++; $display("FAIL fr_fault_cnt: got %0d expected 3", fault_cnt);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL fr_sb_left: got %0d expected 0", sb_q.size());
    end
    do_reset();
  endtask

  task automatic test_simultaneous_and_hold();
    out_ready = 1'b0;
    push_cols(0, 3);
    accept();
    while (cyc < 5) tick();
    n_chk++;
    if (addr_r !== 3'd4 || addr_c !== 3'd3 || en_s2 !== 1'b1) begin
      n_fail++; $display("FAIL sim_setup: addr_r=%0d addr_c=%0d en_s2=%0b expected 4 3 1", addr_r, addr_c, en_s2);
    end
    rfflag = 1'b1;
    cfflag = 1'b1;
    tick();
    rfflag = 1'b0;
    cfflag = 1'b0;
    bump(1);
    push_cols(0, 7);
    n_chk += 2;
    if (addr_r !== 3'd0 || clr_s2 !== 1'b1) begin
      n_fail++; $display("FAIL sim_priority: addr_r=%0d clr_s2=%0b expected 0 1", addr_r, clr_s2);
    end
    if (fault_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL sim_fault_cnt: got %0d expected %0d", fault_cnt, exp_cnt);
    end
    wait_done(15, "sim");
    in_valid = 1'b1;
    rfflag = 1'b1;
    cfflag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || fault_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL hold_done%0d: out_valid=%0b in_ready=%0b busy=%0b fault_cnt=%0d expected 1 0 0 %0d", i, out_valid, in_ready, busy, fault_cnt, exp_cnt);
      end
    end
    in_valid = 1'b0;
    rfflag = 1'b0;
    cfflag = 1'b0;
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: in_ready=%0b out_valid=%0b expected 1 0", in_ready, out_valid);
    end
    tick();
    n_chk += 2;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_idle: in_ready=%0b busy=%0b expected 1 0", in_ready, busy);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sim_sb_left: got %0d expected 0", sb_q.size());
    end
  endtask

  task automatic test_midrun_reset();
    push_cols(0, 7);
    accept();
    while (cyc < 6) tick();
    n_chk++;
    if (addr_r !== 3'd5) begin
      n_fail++; $display("FAIL mr_setup: addr_r got %0d expected 5", addr_r);
    end
    sb_q.delete();
    #2;
    reset = 1'b0;
    #1;
    exp_cnt = 8'd0;
    n_chk++;
    if (outs !== RST_VEC) begin
      n_fail++; $display("FAIL mr_async: got %h expected %h", outs, RST_VEC);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    push_cols(0, 7);
    accept();
    wait_done(10, "mr");
    n_chk += 2;
    if (fault_cnt !== 8'd0) begin
      n_fail++; $display("FAIL mr_fault_cnt: got %0d expected 0", fault_cnt);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL mr_sb_left: got %0d expected 0", sb_q.size());
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      int hits[8] = '{default: 0};
      int n = 0;
      push_cols(0, 7);
      accept();
      while (!out_valid && n < 80) begin
        rfflag = busy && (hits[addr_r] < 2);
        if (rfflag) begin
          hits[addr_r]++;
          bump(1);
        end
        tick();
        n++;
      end
      rfflag = 1'b0;
      n_chk += 2;
      if (!out_valid || cyc !== 26) begin
        n_fail++; $display("FAIL sat_frame%0d: out_valid=%0b at cycle %0d expected 1 at cycle 26", f, out_valid, cyc);
      end
      if (fault_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL sat_cnt%0d: got %0d expected %0d", f, fault_cnt, exp_cnt);
      end
      tick();
    end
    n_chk += 2;
    if (fault_cnt !== 8'd255 || err !== 1'b0) begin
      n_fail++; $display("FAIL sat_final: fault_cnt=%0d err=%0b expected 255 0", fault_cnt, err);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sat_sb_left: got %0d expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_row_retry();
    test_row_fatal();
    test_frame_restart();
    test_simultaneous_and_hold();
    test_midrun_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr_frame_sched.md
Name: tmr_frame_sched

Overview:
- Frame scheduler for the two-stage TMR neuron datapath.
- Accepts one input vector per frame and sweeps the hidden-neuron address through S rows for stage 1.
- Drives stage 2 one cycle behind stage 1, matching the registered hidden value.
- Recovers from TMR fault flags: retries a single row on a stage-1 fault, restarts the whole frame on a stage-2 fault, and raises a sticky error when retries are exhausted.

Parameters:
S, 8, number of hidden neurons (rows per frame)
AW, 3, address width (log2 S)
MAX_RETRY, 3, stage-1 retries allowed per row address
FRAME_RETRY, 2, frame restarts allowed per accepted frame
CNTW, 8, width of saturating fault counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input vector available
in_ready  out  1  scheduler idle; frame accepted when in_valid & in_ready
out_valid  out  1  stage-2 output Y complete and held
out_ready  in  1  consumer takes result
rfflag  in  1  stage-1 TMR disagreement for current addr_r (same cycle)
cfflag  in  1  stage-2 TMR disagreement for current addr_c (same cycle)
addr_r  out  AW  stage-1 row address
addr_c  out  AW  stage-2 column address (addr_r delayed one cycle)
en_s2  out  1  stage-2 accumulate enable
clr_s2  out  1  stage-2 accumulator clear
busy  out  1  state is RUN or DRAIN
err  out  1  sticky unrecoverable fault
fault_cnt  out  CNTW  qualified fault events, saturating

Behaviour:
- States: IDLE, RUN, DRAIN, DONE, ERR. Async reset (reset=0) forces IDLE immediately, including mid-frame.
- Reset values: addr_r=0, addr_c=0, en_s2=0, clr_s2=0, out_valid=0, busy=0, err=0, fault_cnt=0, all retry counters 0. in_ready=1 (IDLE decode).
- in_ready = (state==IDLE). out_valid = (state==DONE). err = (state==ERR).
- IDLE:
  - On in_valid, go to RUN with addr_r=0.
  - Clear row_retry and frame_retry.
- RUN:
  - clr_s2=1 only in the first cycle of a frame or of a frame restart (addr_r=0). en_s2 is 0 in that cycle.
  - slot_v register: set when the previous cycle was RUN with rfflag=0.
  - en_s2 = slot_v. addr_c = addr_r of the previous cycle.
- Stage-1 fault (RUN, rfflag=1, no qualified cfflag):
  - addr_r holds; next cycle en_s2=0; row_retry++.
  - If row_retry==MAX_RETRY already, go to ERR.
  - row_retry clears whenever addr_r advances.
- No fault (RUN, rfflag=0):
  - addr_r<S-1: addr_r++.
  - addr_r==S-1: go to DRAIN.
- DRAIN: en_s2=1, addr_c=S-1, addr_r holds S-1. If no qualified cfflag, go to DONE.
- Stage-2 fault (cfflag with en_s2=1, in RUN or DRAIN):
  - Restart frame: next state RUN, addr_r=0, clr_s2=1, row_retry=0, frame_retry++.
  - If frame_retry==FRAME_RETRY already, go to ERR.
  - cfflag takes priority over a simultaneous rfflag.
- Ignored inputs: cfflag when en_s2=0, rfflag outside RUN, in_valid outside IDLE, out_ready outside DONE.
- DONE: hold until out_ready, then go to IDLE. in_ready is 1 on the following cycle (no same-cycle accept).
- ERR: all enables 0, in_ready=0. Exit only via reset.
- fault_cnt increments by 1 per cycle with any qualified fault (simultaneous faults count 1). Saturates at 2^CNTW-1.
- Fault-free latency, accept edge = cycle 0:
  - RUN cycles 1..S, DRAIN at S+1, out_valid at S+2.
  - S=8: out_valid first high in cycle 10.
  - en_s2 high in exactly S cycles per frame.

Test Plan:
- Fault-free frame, S=8, out_ready=1 → addr_r 0..7 in cycles 1..8; addr_c 0..7 with en_s2=1 in cycles 2..9; clr_s2 only in cycle 1; out_valid cycle 10 only; in_ready back cycle 11.
- rfflag for one cycle at addr_r=3 → addr_r=3 repeats; en_s2=0 the next cycle; out_valid at cycle 11; fault_cnt=1.
- rfflag held at addr_r=5 → 3 retries, then err=1 on the 4th flag; in_ready stays 0; only reset clears it.
- cfflag at addr_c=6 → next cycle addr_r=0, clr_s2=1; frame reruns fully; two more restarts in the same frame → ERR; fault_cnt=3.
- rfflag and cfflag in the same cycle (addr_r=4, addr_c=3) → frame restart, not row retry; fault_cnt +1.
- Reset asserted mid-RUN at addr_r=5 → all outputs at reset values asynchronously; after release, a new frame is accepted and completes normally. Also hold out_ready=0 for 5 cycles in DONE → out_valid held, in_valid ignored.
